// File: rtl/pulse_sorter_mc.sv
// Multi-channel pulse detector: inversion, saturating abs, hysteresis/min-width
// qualification, peak capture, event counting and a per-channel pulse stretcher.
module pulse_sorter_mc #(
  parameter int unsigned          NCH     = 2,
  parameter int unsigned          DW      = 14,
  parameter int unsigned          CW      = 16,
  parameter logic signed [DW-1:0] OUT_AMP = 14'sd4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    invert,
  input  logic [DW-1:0]     thr_hi,
  input  logic [DW-1:0]     thr_lo,
  input  logic [CW-1:0]     min_width,
  input  logic [CW-1:0]     stretch_len,
  input  logic              mode_oneshot,
  input  logic              cnt_clr,
  output logic [NCH-1:0]    pulse,
  output logic [NCH*DW-1:0] out_level,
  output logic [NCH-1:0]    event_stb,
  output logic [NCH*DW-1:0] peak,
  output logic [NCH*32-1:0] count
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_QUAL = 2'd1, S_ACTIVE = 2'd2} state_t;

  localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

  logic          a_valid, b_valid;
  logic [CW-1:0] mw_eff;

  assign mw_eff = (min_width == '0) ? CW'(1) : min_width;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      a_valid <= in_valid;
      b_valid <= a_valid;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [DW-1:0] x_in, a_data;
    logic [DW-1:0]        b_mag, trk, trk_n, peak_q;
    state_t               st, st_n;
    logic [CW-1:0]        run, run_n, tmr, tmr_n;
    logic                 ev, ev_q, pulse_q, pulse_n;
    logic [31:0]          cnt_q;

    assign x_in = in_data[k*DW +: DW];

    // Both negation and abs saturate the most-negative code to +max.
    always_ff @(posedge clk) begin
      if (rst) begin
        a_data <= '0;
        b_mag  <= '0;
      end else begin
        if (invert[k]) a_data <= (x_in == S_MIN) ? S_MAX : -x_in;
        else           a_data <= x_in;
        if (a_data[DW-1]) b_mag <= $unsigned((a_data == S_MIN) ? S_MAX : -a_data);
        else              b_mag <= $unsigned(a_data);
      end
    end

    always_comb begin
      st_n  = st;
      run_n = run;
      trk_n = trk;
      ev    = 1'b0;
      if (b_valid) begin
        case (st)
          S_IDLE: begin
            if (b_mag >= thr_hi) begin
              trk_n = b_mag;
              if (mw_eff == CW'(1)) begin
                st_n = S_ACTIVE;
              end else begin
                st_n  = S_QUAL;
                run_n = CW'(1);
              end
            end
          end
          S_QUAL: begin
            if (b_mag >= thr_hi) begin
              run_n = run + CW'(1);
              if (b_mag > trk) trk_n = b_mag;
              if (run_n >= mw_eff) st_n = S_ACTIVE;
            end else begin
              st_n = S_IDLE;
            end
          end
          S_ACTIVE: begin
            if (b_mag > trk) trk_n = b_mag;
            if (b_mag < thr_lo) begin
              st_n = S_IDLE;
              ev   = 1'b1;
            end
          end
          default: st_n = S_IDLE;
        endcase
      end
    end

    // Timer holds the number of pulse cycles still owed after the current one.
    always_comb begin
      pulse_n = 1'b0;
      tmr_n   = '0;
      if (!mode_oneshot && st_n == S_ACTIVE) begin
        pulse_n = 1'b1;
        tmr_n   = stretch_len;
      end else if (mode_oneshot && st_n == S_ACTIVE && st != S_ACTIVE && tmr == '0) begin
        pulse_n = 1'b1;
        tmr_n   = (stretch_len == '0) ? '0 : stretch_len - CW'(1);
      end else if (tmr != '0) begin
        pulse_n = 1'b1;
        tmr_n   = tmr - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st      <= S_IDLE;
        run     <= '0;
        trk     <= '0;
        tmr     <= '0;
        pulse_q <= 1'b0;
        ev_q    <= 1'b0;
        peak_q  <= '0;
        cnt_q   <= '0;
      end else begin
        st      <= st_n;
        run     <= run_n;
        trk     <= trk_n;
        tmr     <= tmr_n;
        pulse_q <= pulse_n;
        ev_q    <= ev;
        if (ev) peak_q <= trk_n;
        if (cnt_clr)                cnt_q <= '0;
        else if (ev && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
      end
    end

    assign pulse[k]                = pulse_q;
    assign event_stb[k]            = ev_q;
    assign out_level[k*DW +: DW]   = pulse_q ? OUT_AMP : '0;
    assign peak[k*DW +: DW]        = peak_q;
    assign count[k*32 +: 32]       = cnt_q;
  end

endmodule

// File: tb/tb_pulse_sorter_mc.sv
// Bench for pulse_sorter_mc: directed table, corner sequences and randomized
// traffic checked against a cycle-indexed behavioural model.
module tb_pulse_sorter_mc;
  localparam int NCH = 2;
  localparam int DW  = 14;
  localparam int CW  = 16;
  localparam int AMP = 4095;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [NCH*DW-1:0] in_data = '0;
  logic [NCH-1:0]    invert = '0;
  logic [DW-1:0]     thr_hi = 14'd1000;
  logic [DW-1:0]     thr_lo = 14'd800;
  logic [CW-1:0]     min_width = 16'd1;
  logic [CW-1:0]     stretch_len = 16'd4;
  logic              mode_oneshot = 1'b0;
  logic              cnt_clr = 1'b0;
  logic [NCH-1:0]    pulse;
  logic [NCH*DW-1:0] out_level;
  logic [NCH-1:0]    event_stb;
  logic [NCH*DW-1:0] peak;
  logic [NCH*32-1:0] count;

  pulse_sorter_mc #(.NCH(NCH), .DW(DW), .CW(CW), .OUT_AMP(14'sd4095)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .invert(invert),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .min_width(min_width), .stretch_len(stretch_len),
    .mode_oneshot(mode_oneshot), .cnt_clr(cnt_clr), .pulse(pulse), .out_level(out_level),
    .event_stb(event_stb), .peak(peak), .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: two-stage sample delay, then event/stretch bookkeeping by cycle number.
  bit     pv0, pv1;
  int     pm0[NCH], pm1[NCH];
  bit     m_in[NCH];
  int     m_run[NCH], m_pk[NCH], m_last[NCH], m_osend[NCH], m_peak[NCH];
  longint m_cnt[NCH];
  bit     m_evt[NCH], m_pulse[NCH];
  int     hi_cnt[NCH], rises[NCH];
  bit     prev_p[NCH];
  bit     hot[NCH];

  typedef struct {
    int data;
    bit p;
    bit ev;
    int pk;
    int cnt;
  } vec_t;
  vec_t tbl[12];

  function automatic int mag_of(int v, bit inv);
    int r = v;
    if (inv) r = -r;
    if (r > 8191) r = 8191;
    if (r < 0) r = -r;
    if (r > 8191) r = 8191;
    return r;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    pv0 = 0; pv1 = 0;
    for (int k = 0; k < NCH; k++) begin
      pm0[k] = 0; pm1[k] = 0; m_in[k] = 0; m_run[k] = 0; m_pk[k] = 0;
      m_last[k] = -1000000; m_osend[k] = 0; m_peak[k] = 0; m_cnt[k] = 0;
      m_evt[k] = 0; m_pulse[k] = 0;
    end
  endtask

  task automatic clr_stats();
    for (int k = 0; k < NCH; k++) begin
      hi_cnt[k] = 0; rises[k] = 0;
    end
  endtask

  task automatic model_step(int d0, int d1);
    int mw, sl, m;
    bit was, ev;
    int dd[NCH];
    dd[0] = d0; dd[1] = d1;
    cyc++;
    if (rst) begin
      model_clear();
      return;
    end
    mw = (min_width == 0) ? 1 : int'(min_width);
    sl = int'(stretch_len);
    for (int k = 0; k < NCH; k++) begin
      was = m_in[k]; ev = 0; m = pm1[k];
      if (pv1) begin
        if (!m_in[k]) begin
          if (m >= int'(thr_hi)) begin
            m_run[k]++;
            m_pk[k] = (m_run[k] == 1) ? m : ((m > m_pk[k]) ? m : m_pk[k]);
            if (m_run[k] >= mw) m_in[k] = 1;
          end else begin
            m_run[k] = 0;
          end
        end else begin
          if (m > m_pk[k]) m_pk[k] = m;
          if (m < int'(thr_lo)) begin
            m_in[k] = 0; m_run[k] = 0; ev = 1;
          end
        end
      end
      if (ev && m_cnt[k] < 64'hFFFF_FFFF) m_cnt[k]++;
      if (cnt_clr) m_cnt[k] = 0;
      m_evt[k] = ev;
      if (ev) m_peak[k] = m_pk[k];
      if (!mode_oneshot) begin
        if (m_in[k]) m_last[k] = cyc;
        m_pulse[k] = (cyc - m_last[k]) <= sl;
      end else begin
        if (m_in[k] && !was && cyc >= m_osend[k]) m_osend[k] = cyc + ((sl < 1) ? 1 : sl);
        m_pulse[k] = cyc < m_osend[k];
      end
    end
    pv1 = pv0;
    pm1 = pm0;
    pv0 = in_valid;
    for (int k = 0; k < NCH; k++) pm0[k] = mag_of(dd[k], invert[k]);
  endtask

  task automatic step(bit v, int d0, int d1);
    in_valid = v;
    in_data  = {d1[DW-1:0], d0[DW-1:0]};
    model_step(d0, d1);
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("pulse%0d", k), longint'(pulse[k]), longint'(m_pulse[k]));
      chk($sformatf("out_level%0d", k), longint'(out_level[k*DW +: DW]), m_pulse[k] ? AMP : 0);
      chk($sformatf("event_stb%0d", k), longint'(event_stb[k]), longint'(m_evt[k]));
      chk($sformatf("peak%0d", k), longint'(peak[k*DW +: DW]), longint'(m_peak[k]));
      chk($sformatf("count%0d", k), longint'(count[k*32 +: 32]), m_cnt[k]);
      if (pulse[k]) hi_cnt[k]++;
      if (pulse[k] && !prev_p[k]) rises[k]++;
      prev_p[k] = pulse[k];
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b1, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 0, 0);
    step(1'b1, 0, 0);
    rst = 1'b0;
    clr_stats();
  endtask

  function automatic int gen(bit h);
    int m, lo_b;
    if ($urandom_range(0, 30) == 0) return -8192;
    if (h) m = int'($urandom_range(8191, int'(thr_hi)));
    else begin
      lo_b = (thr_lo > 0) ? int'(thr_lo) - 1 : 0;
      m = int'($urandom_range(lo_b, 0));
    end
    if ($urandom_range(0, 1) == 1) m = -m;
    return m;
  endfunction

  initial begin
    model_clear();
    clr_stats();
    for (int k = 0; k < NCH; k++) prev_p[k] = 0;

    // Reset holds every output at zero regardless of input activity.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, gen(1'b1), gen(1'b1));
      chk("rst_flags", longint'({pulse, event_stb}), 0);
      chk("rst_level", longint'(out_level), 0);
      chk("rst_peak", longint'(peak), 0);
      chk("rst_count", longint'(count), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 100, -100);
      chk("post_rst_flags", longint'({pulse, event_stb}), 0);
      chk("post_rst_count", longint'(count), 0);
    end

    // Basic event, one row per clock: sample in, outputs observed after that edge.
    tbl[0]  = '{0,    0, 0, 0,    0};
    tbl[1]  = '{1200, 0, 0, 0,    0};
    tbl[2]  = '{1500, 0, 0, 0,    0};
    tbl[3]  = '{1100, 1, 0, 0,    0};
    tbl[4]  = '{700,  1, 0, 0,    0};
    tbl[5]  = '{0,    1, 0, 0,    0};
    tbl[6]  = '{0,    1, 1, 1500, 1};
    tbl[7]  = '{0,    1, 0, 1500, 1};
    tbl[8]  = '{0,    1, 0, 1500, 1};
    tbl[9]  = '{0,    1, 0, 1500, 1};
    tbl[10] = '{0,    0, 0, 1500, 1};
    tbl[11] = '{0,    0, 0, 1500, 1};
    thr_hi = 14'd1000; thr_lo = 14'd800; min_width = 16'd1; stretch_len = 16'd4;
    mode_oneshot = 1'b0; invert = '0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].data, 0);
      chk($sformatf("tbl%0d_pulse", i), longint'(pulse[0]), longint'(tbl[i].p));
      chk($sformatf("tbl%0d_level", i), longint'(out_level[DW-1:0]), tbl[i].p ? AMP : 0);
      chk($sformatf("tbl%0d_evt", i), longint'(event_stb[0]), longint'(tbl[i].ev));
      chk($sformatf("tbl%0d_peak", i), longint'(peak[DW-1:0]), tbl[i].pk);
      chk($sformatf("tbl%0d_count", i), longint'(count[31:0]), tbl[i].cnt);
    end

    // Threshold boundaries: mag == thr_hi arms, mag == thr_lo does not release.
    do_reset();
    step(1'b1, 1000, 0); step(1'b1, 800, 0); step(1'b1, 799, 0);
    idle(8);
    chk("bound_count", longint'(count[31:0]), 1);
    chk("bound_rises", rises[0], 1);
    chk("bound_peak", longint'(peak[DW-1:0]), 1000);

    // Qualification: a two-sample glitch is rejected when three are required.
    min_width = 16'd3; stretch_len = 16'd2;
    do_reset();
    step(1'b1, 0, 1200); step(1'b1, 0, 1200); step(1'b1, 0, 500);
    idle(6);
    chk("glitch_count", longint'(count[63:32]), 0);
    chk("glitch_rises", rises[1], 0);
    step(1'b1, 0, 1200); step(1'b1, 0, 1200); step(1'b1, 0, 1200); step(1'b1, 0, 0);
    idle(8);
    chk("qual_count", longint'(count[63:32]), 1);
    chk("qual_rises", rises[1], 1);

    // Inversion of -8192 and plain abs of -8192 both saturate to 8191, same-cycle events.
    min_width = 16'd1; stretch_len = 16'd1; thr_hi = 14'd8000; invert = 2'b01;
    do_reset();
    step(1'b1, -8192, -8192);
    idle(6);
    chk("sat_peak0", longint'(peak[DW-1:0]), 8191);
    chk("sat_peak1", longint'(peak[2*DW-1:DW]), 8191);
    chk("sat_count0", longint'(count[31:0]), 1);
    chk("sat_count1", longint'(count[63:32]), 1);

    // One-shot: second entry during the shot is counted but not re-triggered.
    thr_hi = 14'd1000; invert = '0; mode_oneshot = 1'b1; stretch_len = 16'd10;
    do_reset();
    step(1'b1, 1200, 0); step(1'b1, 0, 0); step(1'b1, 0, 0); step(1'b1, 0, 0);
    step(1'b1, 1200, 0);
    idle(16);
    chk("os_width", hi_cnt[0], 10);
    chk("os_rises", rises[0], 1);
    chk("os_count", longint'(count[31:0]), 2);

    // in_valid gaps inside an event, then cnt_clr on the strobe cycle.
    mode_oneshot = 1'b0; stretch_len = 16'd0;
    do_reset();
    step(1'b1, 1200, 0); step(1'b0, 0, 0); step(1'b1, 1300, 0); step(1'b0, 50, 0);
    step(1'b0, 50, 0); step(1'b1, 1100, 0); step(1'b1, 0, 0); step(1'b1, 0, 0);
    cnt_clr = 1'b1;
    step(1'b1, 0, 0);
    cnt_clr = 1'b0;
    chk("clr_evt", longint'(event_stb[0]), 1);
    chk("clr_count", longint'(count[31:0]), 0);
    chk("clr_peak", longint'(peak[DW-1:0]), 1300);
    idle(3);
    chk("gap_rises", rises[0], 1);
    chk("gap_width", hi_cnt[0], 6);
    chk("clr_count_after", longint'(count[31:0]), 0);

    // Reset in the middle of an event discards it.
    stretch_len = 16'd3;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1500, 1500);
    rst = 1'b1;
    step(1'b1, 1500, 1500);
    rst = 1'b0;
    chk("midrst_pulse", longint'(pulse), 0);
    chk("midrst_level", longint'(out_level), 0);
    idle(6);
    chk("midrst_count", longint'(count), 0);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 20; seg++) begin
      thr_hi       = 14'($urandom_range(6000, 500));
      thr_lo       = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(7000, int'(thr_hi)))
                                                 : 14'($urandom_range(int'(thr_hi), 100));
      min_width    = 16'($urandom_range(3, 0));
      stretch_len  = 16'($urandom_range(6, 0));
      mode_oneshot = ($urandom_range(0, 1) == 1);
      invert       = 2'($urandom_range(3, 0));
      do_reset();
      for (int k = 0; k < NCH; k++) hot[k] = 0;
      for (int i = 0; i < 150; i++) begin
        for (int k = 0; k < NCH; k++) if ($urandom_range(0, 5) == 0) hot[k] = ~hot[k];
        cnt_clr = ($urandom_range(0, 40) == 0);
        rst     = ($urandom_range(0, 200) == 0);
        step($urandom_range(0, 9) != 0, gen(hot[0]), gen(hot[1]));
      end
      cnt_clr = 1'b0;
      rst     = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_sorter_mc.md
# pulse_sorter_mc

Multi-channel pulse detector for the sorting datapath: takes NCH signed ADC sample streams and performs per-channel optional inversion, saturating absolute value, hysteresis threshold detection with minimum-width qualification, peak capture, event counting, and a configurable pulse stretcher. It sits between the ADC capture block and the DAC driver and supersedes the single-channel abs/square-wave/enhance chain. It drives both the DAC-level output and per-channel event/peak status for the processor side.

## Interface
- NCH, 2, number of independent channels
- DW, 14, sample width (signed two's complement)
- CW, 16, width of min_width / stretch_len counters
- OUT_AMP, 14'sd4095, DAC level driven while a channel pulse is high (DW bits, signed)
- clk  in  1  single clock (100 MHz domain); all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  qualifies in_data for all channels this cycle
- in_data  in  NCH*DW  channel k samples at [k*DW +: DW]
- invert  in  NCH  bit k negates channel k before abs
- thr_hi  in  DW  unsigned arm threshold (shared by all channels)
- thr_lo  in  DW  unsigned release threshold
- min_width  in  CW  consecutive valid samples >= thr_hi needed to qualify; 0 treated as 1
- stretch_len  in  CW  pulse hold/one-shot length in clk cycles
- mode_oneshot  in  1  0 = follow+hold, 1 = fixed-width one-shot
- cnt_clr  in  1  clears all event counters
- pulse  out  NCH  per-channel detection pulse
- out_level  out  NCH*DW  OUT_AMP when pulse[k] high, else 0
- event_stb  out  NCH  one-cycle strobe at end of each qualified event
- peak  out  NCH*DW  unsigned peak magnitude of last completed event
- count  out  NCH*32  per-channel completed-event counter

## Operation
- Stage A: register in_data and in_valid; negate channel k if invert[k]. Negating the most-negative value saturates to +max.
- Stage B: magnitude = |x|, saturating (most-negative -> 2^(DW-1)-1); register with valid.
- Stage C per-channel FSM, advancing only on valid samples; invalid samples hold state, run counter and peak tracker.
  - IDLE: mag >= thr_hi -> ACTIVE if effective min_width = 1, else QUAL with run = 1; peak tracker loaded with mag.
  - QUAL: mag >= thr_hi -> run+1, track peak; run+1 == min_width -> ACTIVE. mag < thr_hi -> IDLE, no event, no count.
  - ACTIVE: track peak = max(peak, mag); mag < thr_lo -> IDLE, event_stb high one cycle, peak output updated, count+1.
- thr_lo > thr_hi is legal: ACTIVE exits on the first valid sample below thr_lo.
- count saturates at 2^32-1. cnt_clr zeroes all counts; if cnt_clr coincides with an event, the result is 0.
- Stretcher, per channel, runs every cycle regardless of in_valid:
  - Follow+hold: pulse is high while in ACTIVE, and for stretch_len cycles after leaving it. Re-entering ACTIVE during the hold keeps pulse high continuously.
  - One-shot: entering ACTIVE while the timer is idle starts pulse for exactly max(stretch_len,1) cycles. Entries during the one-shot are ignored by the stretcher but are still counted.
- mode_oneshot, stretch_len and the thresholds are sampled live and are meant to be changed only while channels are idle.

## Timing
- Reset values: pulse = 0, out_level = 0, event_stb = 0, peak = 0, count = 0. FSMs go to IDLE, stretch timers to 0, pipeline valids to 0.
- Latency, in_data at cycle t to pulse/out_level rising: t+3 when min_width = 1; each additional qualifying sample adds one valid cycle.
- The sample below thr_lo at cycle t causes event_stb and the peak/count update at t+3.
- Follow+hold: pulse falls at t+3+stretch_len.
- rst asserted mid-event: all outputs are 0 on the next cycle; the event is discarded and not counted.
- Channels are fully independent. Simultaneous events on several channels each strobe in the same cycle.

## Test plan
- Reset: drive random data with rst high for 5 cycles. Required: every output 0. Release rst with mag < thr_lo. Required: outputs stay 0.
- Basic event: DW=14, thr_hi=1000, thr_lo=800, min_width=1, stretch_len=4, ch0 samples 0,1200,1500,1100,700,0. Required: pulse[0] rises 3 cycles after the 1200 sample. event_stb[0] fires 3 cycles after the 700 sample, with peak=1500 and count=1. pulse falls 4 cycles later.
- Qualification/glitch: min_width=3, ch1 samples 1200,1200,500. Required: no pulse, count 0. Then 3×1200 followed by 0. Required: pulse rises after the 3rd sample, count=1.
- Inversion/saturation: invert[0]=1, sample -8192, thr_hi=8000. Required: mag 8191, event detected, peak=8191.
- One-shot: mode_oneshot=1, stretch_len=10, two events 4 cycles apart on ch0. Required: a single 10-cycle pulse, count=2.
- in_valid gaps and cnt_clr: toggle in_valid inside an ACTIVE event. Required: state holds, one event. Assert cnt_clr on the same cycle as event_stb. Required: count=0.
